ysyx_24110015_axi_arbiter: RTL and testbench
============================================

# ysyx_24110015_axi_arbiter

Two-master, one-slave AXI4-Lite arbiter. It shares the single data/instruction memory port between the IFU (read-only master 0) and the LSU (read/write master 1). It sits between the fetch/load-store units and the AXI-to-memory bridge. It grants one whole transaction at a time and routes every channel of the granted master to the slave.

## Interface
Parameters:
- none; all address and data buses are fixed at 32 bits, and responses at 2 bits.

Ports (name, direction, width, meaning). Each channel group is on one line.
- clk  in  1  — the single clock.
- rst  in  1  — synchronous, active-high reset.
- ifu_araddr in 32, ifu_arvalid in 1, ifu_arready out 1  — IFU AR channel.
- ifu_rdata out 32, ifu_rresp out 2, ifu_rvalid out 1, ifu_rready in 1  — IFU R channel.
- lsu_araddr in 32, lsu_arvalid in 1, lsu_arready out 1  — LSU AR channel.
- lsu_rdata out 32, lsu_rresp out 2, lsu_rvalid out 1, lsu_rready in 1  — LSU R channel.
- lsu_awaddr in 32, lsu_awvalid in 1, lsu_awready out 1  — LSU AW channel.
- lsu_wdata in 32, lsu_wstrb in 4, lsu_wvalid in 1, lsu_wready out 1  — LSU W channel.
- lsu_bresp out 2, lsu_bvalid out 1, lsu_bready in 1  — LSU B channel.
- s_araddr out 32, s_arvalid out 1, s_arready in 1  — slave AR channel.
- s_rdata in 32, s_rresp in 2, s_rvalid in 1, s_rready out 1  — slave R channel.
- s_awaddr out 32, s_awvalid out 1, s_awready in 1  — slave AW channel.
- s_wdata out 32, s_wstrb out 4, s_wvalid out 1, s_wready in 1  — slave W channel.
- s_bresp in 2, s_bvalid in 1, s_bready out 1  — slave B channel.

## Operation
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR. Reset state is IDLE.
- Requests seen in IDLE:
  - IFU read request: ifu_arvalid.
  - LSU read request: lsu_arvalid.
  - LSU write request: lsu_awvalid | lsu_wvalid.
- If the LSU presents both a read and a write request, the read is granted first.
- Arbitration between IFU and LSU is fixed or round-robin; see Configuration.
- IFU_RD / LSU_RD:
  - Route the granted master's AR and R channels to the slave; master ar*/r* ↔ s_ar*/s_r*.
  - Drive all write-channel outputs to the slave as 0.
- LSU_WR:
  - Route the LSU AW, W and B channels to the slave.
  - AW and W are forwarded independently and may handshake in either order or in the same cycle.
- Exit conditions:
  - Read states go to IDLE on s_rvalid & s_rready.
  - LSU_WR goes to IDLE on s_bvalid & s_bready.
- Non-granted master:
  - arready, awready, wready, rvalid and bvalid are all 0.
  - rdata/rresp/bresp are broadcast from the slave but are only meaningful under valid.
- In IDLE:
  - All slave valid/ready outputs are 0; s_araddr, s_awaddr, s_wdata and s_wstrb are 0.
  - All master ready/valid outputs are 0.
- Response codes pass through unmodified; the arbiter never generates a response itself.
- Masters must hold valid and payload until their handshake (AXI rule). The arbiter does not buffer payloads.

## Timing
- Grant latency: one cycle. A request first seen in IDLE at cycle N makes the slave's valid visible at N+1.
- All routing within a granted state is combinational. There is no added latency on any handshake.
- At least one IDLE cycle separates consecutive transactions. The earliest back-to-back grant for a waiting requester is on the cycle after completion + 1.
- Request arriving during another master's transaction: it waits (ready=0) and is arbitrated at the next IDLE.
- Request deasserted in IDLE before it is granted: no grant is issued.
- Reset mid-transaction: on the next edge the FSM returns to IDLE, all valid/ready outputs go to 0, and the round-robin pointer resets. The outstanding slave transaction is abandoned; the slave must also be reset.
- Reset values:
  - All *valid and *ready outputs are 0.
  - s_* payload outputs are 0.
  - last_grant = LSU.

## Configuration
- Macro: YSYX_24110015_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_grant register is updated when each transaction completes.
  - On a simultaneous IFU/LSU request, the master not served last wins.
  - After reset the IFU wins the first tie.
- Undefined: fixed priority, LSU over IFU.
  - The last_grant register is not instantiated.
  - A continuous LSU request can starve the IFU.

## Test plan
- Single IFU read: ifu_araddr=0x8000_0000 is held; the slave returns rdata=0x0000_0413, rresp=0 two cycles after AR.
  - Required: s_arvalid rises the cycle after ifu_arvalid.
  - Required: ifu_rvalid coincides with s_rvalid, with matching data.
  - Required: FSM is back in IDLE the cycle after the R handshake.
- LSU write with W before AW: wvalid is asserted one cycle before awvalid, with addr 0x8000_1000, wdata 0xDEAD_BEEF, wstrb 0xF.
  - Required: s_wstrb=0xF and the data pass through.
  - Required: the FSM stays in LSU_WR until the B handshake, then returns to IDLE.
- Simultaneous IFU and LSU read in IDLE:
  - With the macro undefined, LSU is granted and ifu_arready stays 0 until the next IDLE.
  - With the macro defined, IFU is granted first, then LSU, then IFU on the following tie.
- IFU request arrives mid-LSU read: the IFU is granted only after the LSU R handshake plus one IDLE cycle; its address is never seen on s_araddr before then.
- Slave returns rresp=2'b10 (SLVERR) on an LSU read: lsu_rresp=2'b10 with lsu_rvalid=1, and the arbiter returns to IDLE normally.
- rst asserted during LSU_WR after AW is accepted: on the next edge all outputs are 0 and the state is IDLE. After deasserting rst, an IFU request is granted with a one-cycle latency.

Source files
------------

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter; YSYX_24110015_ARB_RR_EN selects round-robin, else LSU has fixed priority.
// Latency: one cycle from request in IDLE to slave valid, then purely combinational routing of every channel.
// Backpressure: the non-granted master sees ready/valid held at 0 until the next IDLE cycle; payloads are never buffered.
module ysyx_24110015_axi_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFU_RD = 2'd1;
    localparam logic [1:0] LSU_RD = 2'd2;
    localparam logic [1:0] LSU_WR = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ifu_req;
    logic       lsu_req;
    logic       lsu_wins;
    logic       rd_done;
    logic       wr_done;

    assign ifu_req = ifu_arvalid;
    assign lsu_req = lsu_arvalid | lsu_awvalid | lsu_wvalid;
    assign rd_done = s_rvalid & s_rready;
    assign wr_done = s_bvalid & s_bready;

`ifdef YSYX_24110015_ARB_RR_EN
    logic last_grant; // 1: LSU was served last, 0: IFU was served last

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (state == IFU_RD && rd_done) begin
            last_grant <= 1'b0;
        end else if ((state == LSU_RD && rd_done) || (state == LSU_WR && wr_done)) begin
            last_grant <= 1'b1;
        end
    end

    assign lsu_wins = lsu_req & (~ifu_req | ~last_grant);
`else
    assign lsu_wins = lsu_req;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lsu_wins) begin
                    state_nxt = lsu_arvalid ? LSU_RD : LSU_WR;
                end else if (ifu_req) begin
                    state_nxt = IFU_RD;
                end
            end
            IFU_RD, LSU_RD: if (rd_done) state_nxt = IDLE;
            LSU_WR:         if (wr_done) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response payloads are shared wires; only the granted master sees valid.
    assign ifu_rdata = s_rdata;
    assign ifu_rresp = s_rresp;
    assign lsu_rdata = s_rdata;
    assign lsu_rresp = s_rresp;
    assign lsu_bresp = s_bresp;

    always_comb begin
        s_araddr    = 32'd0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awaddr    = 32'd0;
        s_awvalid   = 1'b0;
        s_wdata     = 32'd0;
        s_wstrb     = 4'd0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        case (state)
            IFU_RD: begin
                s_araddr    = ifu_araddr;
                s_arvalid   = ifu_arvalid;
                s_rready    = ifu_rready;
                ifu_arready = s_arready;
                ifu_rvalid  = s_rvalid;
            end
            LSU_RD: begin
                s_araddr    = lsu_araddr;
                s_arvalid   = lsu_arvalid;
                s_rready    = lsu_rready;
                lsu_arready = s_arready;
                lsu_rvalid  = s_rvalid;
            end
            LSU_WR: begin
                s_awaddr    = lsu_awaddr;
                s_awvalid   = lsu_awvalid;
                s_wdata     = lsu_wdata;
                s_wstrb     = lsu_wstrb;
                s_wvalid    = lsu_wvalid;
                s_bready    = lsu_bready;
                lsu_awready = s_awready;
                lsu_wready  = s_wready;
                lsu_bvalid  = s_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Bench for the two-master AXI4-Lite arbiter: directed scenarios then randomized masters/slave,
// every cycle compared against a transaction-owner reference model.
module tb_ysyx_24110015_axi_arbiter;

`ifdef YSYX_24110015_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int O_NONE = 0, O_IFU = 1, O_LRD = 2, O_LWR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0, s_rdata = '0;
    logic        ifu_arvalid = 0, ifu_rready = 0, lsu_arvalid = 0, lsu_rready = 0;
    logic        lsu_awvalid = 0, lsu_wvalid = 0, lsu_bready = 0;
    logic [3:0]  lsu_wstrb = '0;
    logic        s_arready = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;

    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid;
    logic [31:0] ifu_rdata, lsu_rdata, s_araddr, s_awaddr, s_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [3:0]  s_wstrb;

    ysyx_24110015_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which master owns the slave, and who was served last (1 = LSU).
    int own = O_NONE;
    bit lg  = 1'b1;

    bit hs_ifu_ar, hs_ifu_r, hs_lsu_ar, hs_lsu_r, hs_lsu_aw, hs_lsu_w, hs_lsu_b;
    bit hs_s_ar, hs_s_r, hs_s_aw, hs_s_w, hs_s_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance one clock.
    task automatic step();
        logic [31:0] sa, awa, wd;
        logic [3:0]  ws;
        logic        sav, srr, awv, wv, sbr, i_arr, i_rv, l_arr, l_rv, l_awr, l_wr, l_bv;
        logic        lreq, lsu_first;
        int          nxt;
        #1;
        sa = '0; awa = '0; wd = '0; ws = '0;
        {sav, srr, awv, wv, sbr, i_arr, i_rv, l_arr, l_rv, l_awr, l_wr, l_bv} = '0;
        case (own)
            O_IFU: begin sa = ifu_araddr; sav = ifu_arvalid; srr = ifu_rready; i_arr = s_arready; i_rv = s_rvalid; end
            O_LRD: begin sa = lsu_araddr; sav = lsu_arvalid; srr = lsu_rready; l_arr = s_arready; l_rv = s_rvalid; end
            O_LWR: begin
                awa = lsu_awaddr; awv = lsu_awvalid; wd = lsu_wdata; ws = lsu_wstrb; wv = lsu_wvalid;
                sbr = lsu_bready; l_awr = s_awready; l_wr = s_wready; l_bv = s_bvalid;
            end
            default: ;
        endcase
        check("s_ar_r", {30'b0, s_araddr, s_arvalid, s_rready}, {30'b0, sa, sav, srr});
        check("s_aw",   {31'b0, s_awaddr, s_awvalid}, {31'b0, awa, awv});
        check("s_w_b",  {26'b0, s_wdata, s_wstrb, s_wvalid, s_bready}, {26'b0, wd, ws, wv, sbr});
        check("ifu",    {28'b0, ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp},
                        {28'b0, i_arr, i_rv, s_rdata, s_rresp});
        check("lsu",    {23'b0, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid, lsu_rdata, lsu_rresp, lsu_bresp},
                        {23'b0, l_arr, l_rv, l_awr, l_wr, l_bv, s_rdata, s_rresp, s_bresp});

        hs_ifu_ar = ifu_arvalid & ifu_arready;  hs_ifu_r = ifu_rvalid & ifu_rready;
        hs_lsu_ar = lsu_arvalid & lsu_arready;  hs_lsu_r = lsu_rvalid & lsu_rready;
        hs_lsu_aw = lsu_awvalid & lsu_awready;  hs_lsu_w = lsu_wvalid & lsu_wready;
        hs_lsu_b  = lsu_bvalid & lsu_bready;
        hs_s_ar = s_arvalid & s_arready;  hs_s_r = s_rvalid & s_rready;
        hs_s_aw = s_awvalid & s_awready;  hs_s_w = s_wvalid & s_wready;  hs_s_b = s_bvalid & s_bready;

        nxt = own;
        if (rst) begin
            nxt = O_NONE; lg = 1'b1;
        end else begin
            case (own)
                O_NONE: begin
                    lreq      = lsu_arvalid | lsu_awvalid | lsu_wvalid;
                    lsu_first = lreq & (!ifu_arvalid | !RR | !lg);
                    if (lsu_first)        nxt = lsu_arvalid ? O_LRD : O_LWR;
                    else if (ifu_arvalid) nxt = O_IFU;
                end
                O_IFU: if (s_rvalid & srr) begin nxt = O_NONE; lg = 1'b0; end
                O_LRD: if (s_rvalid & srr) begin nxt = O_NONE; lg = 1'b1; end
                default: if (s_bvalid & sbr) begin nxt = O_NONE; lg = 1'b1; end
            endcase
        end
        @(posedge clk);
        #2;
        own = nxt;
    endtask

    // Randomized, protocol-compliant masters and slave.
    int  ifu_ph = 0, rd_ph = 0;
    bit  wr_act = 0, aw_todo = 0, w_todo = 0, r_pend = 0, got_aw = 0, got_w = 0;

    task automatic rand_drive();
        int op;
        if (hs_ifu_ar) begin ifu_arvalid = 0; ifu_ph = 2; end
        if (hs_ifu_r) ifu_ph = 0;
        if (ifu_ph == 0 && $urandom_range(3) == 0) begin
            ifu_arvalid = 1; ifu_araddr = $urandom; ifu_ph = 1;
        end
        ifu_rready = 1'($urandom_range(1));

        if (hs_lsu_ar) begin lsu_arvalid = 0; rd_ph = 2; end
        if (hs_lsu_r)  rd_ph = 0;
        if (hs_lsu_aw) lsu_awvalid = 0;
        if (hs_lsu_w)  lsu_wvalid = 0;
        if (hs_lsu_b)  wr_act = 0;
        if (rd_ph == 0 && !wr_act && $urandom_range(2) == 0) begin
            op = $urandom_range(2);
            if (op != 1) begin lsu_arvalid = 1; lsu_araddr = $urandom; rd_ph = 1; end
            if (op != 0) begin
                wr_act = 1; aw_todo = 1; w_todo = 1;
                lsu_awaddr = $urandom; lsu_wdata = $urandom; lsu_wstrb = 4'($urandom);
            end
        end
        if (aw_todo && $urandom_range(1) == 1) begin lsu_awvalid = 1; aw_todo = 0; end
        if (w_todo && $urandom_range(1) == 1)  begin lsu_wvalid = 1;  w_todo = 0;  end
        lsu_rready = 1'($urandom_range(1));
        lsu_bready = 1'($urandom_range(1));

        if (hs_s_ar) r_pend = 1;
        if (hs_s_r)  begin s_rvalid = 0; r_pend = 0; end
        if (hs_s_aw) got_aw = 1;
        if (hs_s_w)  got_w = 1;
        if (hs_s_b)  begin s_bvalid = 0; got_aw = 0; got_w = 0; end
        if (!s_rvalid) begin s_rdata = $urandom; s_rresp = 2'($urandom); end
        if (!s_bvalid) s_bresp = 2'($urandom);
        if (r_pend && !s_rvalid && $urandom_range(1) == 1) s_rvalid = 1;
        if (got_aw && got_w && !s_bvalid && $urandom_range(1) == 1) s_bvalid = 1;
        s_arready = 1'($urandom_range(1));
        s_awready = 1'($urandom_range(1));
        s_wready  = 1'($urandom_range(1));
    endtask

    logic [31:0] a_ifu, a_lsu;
    bit          win_ifu;

    initial begin
        // Reset: every valid/ready and slave payload output at 0.
        repeat (2) @(posedge clk);
        #2;
        #1;
        check("rst_vr", {52'b0, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, ifu_arready, ifu_rvalid,
                         lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}, 64'd0);
        check("rst_pl", {s_araddr, s_awaddr}, 64'd0);
        check("rst_wd", {28'b0, s_wdata, s_wstrb}, 64'd0);
        step();
        rst = 0;

        // Single IFU read, slave answers two cycles after AR.
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; s_arready = 1;
        step();
        step();
        ifu_arvalid = 0; s_arready = 0;
        step();
        s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = 2'b00; ifu_rready = 1;
        #1;
        check("ifu_r", {29'b0, ifu_rvalid, ifu_rdata, ifu_rresp}, {29'b0, 1'b1, 32'h0000_0413, 2'b00});
        step();
        s_rvalid = 0; ifu_rready = 0;
        step();

        // LSU write with W one cycle ahead of AW.
        lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_awaddr = 32'h8000_1000;
        step();
        lsu_awvalid = 1;
        step();
        s_awready = 1; s_wready = 1;
        #1;
        check("wr_pass", {s_awaddr, s_wdata}, {32'h8000_1000, 32'hDEAD_BEEF});
        check("wr_strb", {60'b0, s_wstrb}, 64'hF);
        step();
        lsu_awvalid = 0; lsu_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1; s_bresp = 2'b00;
        step();
        lsu_bready = 1;
        step();
        s_bvalid = 0; lsu_bready = 0;
        step();

        // Three IFU/LSU read ties; the served master re-requests; SLVERR responses.
        a_ifu = 32'h8000_0100; a_lsu = 32'h8000_2000;
        ifu_arvalid = 1; lsu_arvalid = 1; ifu_araddr = a_ifu; lsu_araddr = a_lsu;
        for (int r = 0; r < 3; r++) begin
            step();
            win_ifu = RR ? (r != 1) : 1'b0;
            s_arready = 1;
            #1;
            check("tie_win", {32'b0, s_araddr}, {32'b0, win_ifu ? ifu_araddr : lsu_araddr});
            step();
            s_arready = 0;
            if (win_ifu) ifu_araddr = ifu_araddr + 32'd4;
            else         lsu_araddr = lsu_araddr + 32'd4;
            s_rvalid = 1; s_rresp = 2'b10; s_rdata = 32'h1234_5678; ifu_rready = 1; lsu_rready = 1;
            #1;
            check("slverr", {61'b0, lsu_rvalid, lsu_rresp}, {61'b0, !win_ifu, 2'b10});
            step();
            s_rvalid = 0; s_rresp = 2'b00; ifu_rready = 0; lsu_rready = 0;
        end
        ifu_arvalid = 0; lsu_arvalid = 0;
        step();
        step();

        // Reset in the middle of a write after AW is accepted, then an IFU grant.
        lsu_awvalid = 1; lsu_awaddr = 32'h8000_3000; s_awready = 1;
        step();
        step();
        lsu_awvalid = 0; s_awready = 0; rst = 1;
        step();
        rst = 0; ifu_arvalid = 1; ifu_araddr = 32'h8000_0040;
        #1;
        check("rst_idle", {59'b0, s_awvalid, s_wvalid, s_bready, lsu_awready, lsu_bvalid}, 64'd0);
        step();
        #1;
        check("rst_regr", {31'b0, s_arvalid, s_araddr}, {31'b0, 1'b1, 32'h8000_0040});
        s_arready = 1;
        step();
        ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; ifu_rready = 1;
        step();
        s_rvalid = 0; ifu_rready = 0;
        step();

        // Randomized traffic.
        {hs_ifu_ar, hs_ifu_r, hs_lsu_ar, hs_lsu_r, hs_lsu_aw, hs_lsu_w, hs_lsu_b} = '0;
        {hs_s_ar, hs_s_r, hs_s_aw, hs_s_w, hs_s_b} = '0;
        for (int c = 0; c < 3000; c++) begin
            rand_drive();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
